// File: rtl/sdram_arbiter.sv
// Two-port arbiter in front of the single SDRAM controller: CPU on port 0, DMA/video on port 1.
// One access is in flight at a time. Completion is taken from the rising edge of mem_q_ready, and a watchdog aborts stuck accesses.
`timescale 1ns/1ps
module sdram_arbiter #(
  parameter bit          ROUND_ROBIN    = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [23:0] p0_addr,
  input  logic [31:0] p0_d,
  output logic [31:0] p0_q,
  output logic        p0_ack,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [23:0] p1_addr,
  input  logic [31:0] p1_d,
  output logic [31:0] p1_q,
  output logic        p1_ack,
  output logic        mem_start,
  output logic        mem_we,
  output logic [23:0] mem_addr,
  output logic [31:0] mem_d,
  input  logic [31:0] mem_q,
  input  logic        mem_q_ready,
  input  logic        mem_busy,
  input  logic        mem_init_done,
  output logic        grant,
  output logic        timeout_err
);

  localparam int unsigned AW = 24;
  localparam int unsigned DW = 32;
  localparam int unsigned TW = 10;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_INIT = 2'd0,
    IDLE      = 2'd1,
    ISSUE     = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_last_grant;
  logic          r_q_ready_d;
  logic [TW-1:0] r_tmo_cnt;
  logic          r_mem_start;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_d;
  logic [DW-1:0] r_p0_q;
  logic [DW-1:0] r_p1_q;
  logic          r_p0_ack;
  logic          r_p1_ack;
  logic          r_grant;
  logic          r_timeout_err;

  logic          w_any_req;
  logic          w_sel;
  logic          w_done;
  logic          w_unused_busy;

  // mem_busy is informational only; sequencing relies on mem_q_ready
  assign w_unused_busy = mem_busy;

  assign w_any_req = p0_req | p1_req;
  assign w_done    = mem_q_ready & ~r_q_ready_d;

  // Port selection for the next grant; under contention either alternate or favour port 0
  always_comb begin
    w_sel = 1'b0;
    if (p0_req && p1_req) begin
      w_sel = ROUND_ROBIN ? ~r_last_grant : 1'b0;
    end else begin
      w_sel = p1_req;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= WAIT_INIT;
      r_last_grant  <= 1'b1;
      r_q_ready_d   <= 1'b0;
      r_tmo_cnt     <= '0;
      r_mem_start   <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_d       <= '0;
      r_p0_q        <= '0;
      r_p1_q        <= '0;
      r_p0_ack      <= 1'b0;
      r_p1_ack      <= 1'b0;
      r_grant       <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_q_ready_d <= mem_q_ready;
      r_p0_ack    <= 1'b0;
      r_p1_ack    <= 1'b0;
      case (r_state)
        WAIT_INIT: begin
          if (mem_init_done) r_state <= IDLE;
        end
        IDLE: begin
          if (w_any_req) begin
            r_mem_we     <= w_sel ? p1_we   : p0_we;
            r_mem_addr   <= w_sel ? p1_addr : p0_addr;
            r_mem_d      <= w_sel ? p1_d    : p0_d;
            r_grant      <= w_sel;
            r_last_grant <= w_sel;
            r_mem_start  <= 1'b1;
            r_tmo_cnt    <= '0;
            r_state      <= ISSUE;
          end
        end
        ISSUE: begin
          // start stays asserted so the controller can service a refresh first
          if (w_done) begin
            r_mem_start <= 1'b0;
            if (!r_mem_we) begin
              if (r_grant) r_p1_q <= mem_q;
              else         r_p0_q <= mem_q;
            end
            if (r_grant) r_p1_ack <= 1'b1;
            else         r_p0_ack <= 1'b1;
            r_state <= IDLE;
          end else if (r_tmo_cnt == TMO_LAST) begin
            r_mem_start   <= 1'b0;
            r_timeout_err <= 1'b1;
            if (r_grant) r_p1_ack <= 1'b1;
            else         r_p0_ack <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
          end
        end
        default: r_state <= WAIT_INIT;
      endcase
    end
  end

  assign mem_start   = r_mem_start;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_d       = r_mem_d;
  assign p0_q        = r_p0_q;
  assign p1_q        = r_p1_q;
  assign p0_ack      = r_p0_ack;
  assign p1_ack      = r_p1_ack;
  assign grant       = r_grant;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: a round-robin instance with a configurable controller model,
// plus a fixed-priority instance used for the contention checks.
`timescale 1ns/1ps
module tb_sdram_arbiter;

  logic        clk;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [23:0] p0_addr, p1_addr;
  logic [31:0] p0_d, p1_d;
  logic        mem_init_done;

  logic [31:0] a_p0_q, a_p1_q, a_mem_d, a_mem_q;
  logic        a_p0_ack, a_p1_ack, a_mem_start, a_mem_we, a_grant, a_timeout_err;
  logic [23:0] a_mem_addr;
  logic        a_ready, a_busy;

  logic [31:0] b_p0_q, b_p1_q, b_mem_d, b_mem_q;
  logic        b_p0_ack, b_p1_ack, b_mem_start, b_mem_we, b_grant, b_timeout_err;
  logic [23:0] b_mem_addr;
  logic        b_ready, b_busy;

  int total = 0;
  int bad   = 0;

  int          m_lat   = 9;
  bit          m_never = 0;
  bit          m_stale = 0;
  logic [31:0] m_rdata = 32'h0;

  sdram_arbiter #(.ROUND_ROBIN(1'b1), .TIMEOUT_CYCLES(1023)) u_rr (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_d(p0_d), .p0_q(a_p0_q), .p0_ack(a_p0_ack),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_d(p1_d), .p1_q(a_p1_q), .p1_ack(a_p1_ack),
    .mem_start(a_mem_start), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_d(a_mem_d),
    .mem_q(a_mem_q), .mem_q_ready(a_ready), .mem_busy(a_busy), .mem_init_done(mem_init_done),
    .grant(a_grant), .timeout_err(a_timeout_err)
  );

  sdram_arbiter #(.ROUND_ROBIN(1'b0), .TIMEOUT_CYCLES(1023)) u_fp (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_d(p0_d), .p0_q(b_p0_q), .p0_ack(b_p0_ack),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_d(p1_d), .p1_q(b_p1_q), .p1_ack(b_p1_ack),
    .mem_start(b_mem_start), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_d(b_mem_d),
    .mem_q(b_mem_q), .mem_q_ready(b_ready), .mem_busy(b_busy), .mem_init_done(mem_init_done),
    .grant(b_grant), .timeout_err(b_timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller model A: ready rises m_lat cycles after start; optionally never, or left high (stale)
  bit a_act, a_wait_low;
  int a_cnt;
  always @(posedge clk) begin
    if (reset) begin
      a_ready <= 0; a_busy <= 0; a_mem_q <= 0; a_act <= 0; a_wait_low <= 0; a_cnt <= 0;
    end else if (a_act) begin
      if (!a_mem_start) begin
        a_act <= 0; a_busy <= 0;
      end else begin
        a_cnt <= a_cnt + 1;
        if (a_cnt == 2) a_ready <= 0;
        if (!m_never && a_cnt == m_lat - 1) begin
          a_ready <= 1; a_mem_q <= m_rdata; a_act <= 0; a_wait_low <= 1;
        end
      end
    end else if (a_wait_low) begin
      if (!a_mem_start) begin
        a_wait_low <= 0;
        if (!m_stale) begin a_ready <= 0; a_busy <= 0; end
      end
    end else if (a_mem_start) begin
      a_act <= 1; a_cnt <= 1; a_busy <= 1;
    end
  end

  // Controller model B: fixed 4-cycle latency, constant read data
  bit b_act, b_wait_low;
  int b_cnt;
  always @(posedge clk) begin
    if (reset) begin
      b_ready <= 0; b_busy <= 0; b_mem_q <= 0; b_act <= 0; b_wait_low <= 0; b_cnt <= 0;
    end else if (b_act) begin
      b_cnt <= b_cnt + 1;
      if (b_cnt == 3) begin
        b_ready <= 1; b_mem_q <= 32'hB0B0_0000; b_act <= 0; b_wait_low <= 1;
      end
    end else if (b_wait_low) begin
      if (!b_mem_start) begin b_wait_low <= 0; b_ready <= 0; b_busy <= 0; end
    end else if (b_mem_start) begin
      b_act <= 1; b_cnt <= 1; b_busy <= 1;
    end
  end

  task automatic run_access(input bit port, input bit we, input logic [23:0] addr, input logic [31:0] d,
                            input int limit, output int lat_k, output int start_hi,
                            output bit start_at_ack, output bit ack_again);
    bit fin;
    if (port) begin p1_we = we; p1_addr = addr; p1_d = d; p1_req = 1; end
    else      begin p0_we = we; p0_addr = addr; p0_d = d; p0_req = 1; end
    lat_k = 0; start_hi = 0; start_at_ack = 1; fin = 0;
    total++;
    while (!fin) begin
      @(negedge clk);
      lat_k++;
      if ((port ? a_p1_ack : a_p0_ack) === 1'b1) begin
        fin = 1; start_at_ack = a_mem_start;
      end else begin
        if (a_mem_start === 1'b1) start_hi++;
        if (lat_k >= limit) begin
          bad++; fin = 1;
          $display("FAIL ack_wait port=%0d: no ack after %0d cycles, required ack", port, lat_k);
        end
      end
    end
    if (port) p1_req = 0; else p0_req = 0;
    @(negedge clk);
    ack_again = ((port ? a_p1_ack : a_p0_ack) === 1'b1);
  endtask

  task automatic do_reset();
    reset = 1; p0_req = 0; p1_req = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1; mem_init_done = 0;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_d = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_d = 0;
    repeat (3) @(negedge clk);
    total++; if (a_mem_start !== 1'b0) begin bad++; $display("FAIL rst_mem_start got=%0b exp=0", a_mem_start); end
    total++; if (a_grant !== 1'b0) begin bad++; $display("FAIL rst_grant got=%0b exp=0", a_grant); end
    total++; if ({a_p0_ack, a_p1_ack, a_timeout_err} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", {a_p0_ack, a_p1_ack, a_timeout_err}); end
    total++; if ({a_p0_q, a_p1_q, a_mem_d, a_mem_addr, a_mem_we} !== '0) begin bad++; $display("FAIL rst_data got=%h/%h/%h/%h/%b exp=0", a_p0_q, a_p1_q, a_mem_d, a_mem_addr, a_mem_we); end
    reset = 0;
  endtask

  task automatic test_init_gating();
    bit seen = 0;
    bit fin = 0;
    int n = 0;
    m_lat = 9; m_rdata = 32'hA5A5_0001;
    p0_we = 0; p0_addr = 24'h000ABC; p0_d = 0; p0_req = 1;
    repeat (50) begin @(negedge clk); if (a_mem_start !== 1'b0) seen = 1; end
    total++; if (seen) begin bad++; $display("FAIL init_block got=start_seen exp=no_start"); end
    mem_init_done = 1;
    @(negedge clk);
    total++; if (a_mem_start !== 1'b0) begin bad++; $display("FAIL init_lat1 got=%0b exp=0", a_mem_start); end
    @(negedge clk);
    total++; if (a_mem_start !== 1'b1) begin bad++; $display("FAIL init_lat2 got=%0b exp=1", a_mem_start); end
    total++; if (a_mem_addr !== 24'h000ABC) begin bad++; $display("FAIL init_addr got=%h exp=000abc", a_mem_addr); end
    while (!fin) begin
      @(negedge clk); n++;
      if (a_p0_ack === 1'b1) fin = 1;
      else if (n > 50) begin fin = 1; total++; bad++; $display("FAIL init_ack got=none exp=ack"); end
    end
    p0_req = 0;
    @(negedge clk);
    total++; if (a_p0_q !== 32'hA5A5_0001) begin bad++; $display("FAIL init_q got=%h exp=a5a50001", a_p0_q); end
  endtask

  task automatic test_single_read();
    int k, sh; bit sa, aa;
    m_lat = 9; m_rdata = 32'hDEAD_BEEF;
    run_access(0, 0, 24'h000123, 32'h0, 50, k, sh, sa, aa);
    total++; if (a_p0_q !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_q got=%h exp=deadbeef", a_p0_q); end
    total++; if (k !== 11) begin bad++; $display("FAIL rd_latency got=%0d exp=11", k); end
    total++; if (sh !== 10) begin bad++; $display("FAIL rd_start_len got=%0d exp=10", sh); end
    total++; if (sa !== 1'b0) begin bad++; $display("FAIL rd_start_at_ack got=%0b exp=0", sa); end
    total++; if (aa !== 1'b0) begin bad++; $display("FAIL rd_ack_width got=2cycles exp=1cycle"); end
    total++; if ({a_mem_we, a_mem_addr} !== {1'b0, 24'h000123}) begin bad++; $display("FAIL rd_fields got=%b/%h exp=0/000123", a_mem_we, a_mem_addr); end
    total++; if (a_p1_q !== 32'h0) begin bad++; $display("FAIL rd_p1_q got=%h exp=0", a_p1_q); end
  endtask

  task automatic test_contention();
    logic [3:0] ga, gb;
    int na = 0, nb = 0, n = 0, b_p1_acks = 0;
    bit pa = 0, pb = 0;
    do_reset();
    m_lat = 5; m_rdata = 32'h5555_AAAA;
    p0_we = 0; p0_addr = 24'h000100; p0_d = 0;
    p1_we = 0; p1_addr = 24'h000200; p1_d = 0;
    p0_req = 1; p1_req = 1;
    ga = '1; gb = '1;
    while ((na < 4 || nb < 4) && n < 300) begin
      @(negedge clk); n++;
      if (a_mem_start && !pa && na < 4) begin ga[na] = a_grant; na++; end
      if (b_mem_start && !pb && nb < 4) begin gb[nb] = b_grant; nb++; end
      if (b_p1_ack === 1'b1) b_p1_acks++;
      pa = a_mem_start; pb = b_mem_start;
    end
    total++; if (na !== 4 || nb !== 4) begin bad++; $display("FAIL cont_count got=%0d/%0d exp=4/4", na, nb); end
    total++; if (ga !== 4'b1010) begin bad++; $display("FAIL rr_seq got=%b exp=1010 (g3..g0)", ga); end
    total++; if (gb !== 4'b0000) begin bad++; $display("FAIL fp_seq got=%b exp=0000 (g3..g0)", gb); end
    total++; if (b_p1_acks !== 0) begin bad++; $display("FAIL fp_p1_ack got=%0d exp=0", b_p1_acks); end
    total++; if ({b_mem_we, b_mem_addr, b_mem_d} !== {1'b0, 24'h000100, 32'h0}) begin bad++; $display("FAIL fp_fields got=%b/%h/%h exp=0/000100/0", b_mem_we, b_mem_addr, b_mem_d); end
    total++; if ({b_p0_q, b_p1_q, b_timeout_err} !== {32'hB0B0_0000, 32'h0, 1'b0}) begin bad++; $display("FAIL fp_q got=%h/%h/%b exp=b0b00000/0/0", b_p0_q, b_p1_q, b_timeout_err); end
    do_reset();
  endtask

  task automatic test_refresh();
    int k, sh; bit sa, aa;
    m_lat = 9; m_rdata = 32'hCAFE_F00D;
    run_access(1, 0, 24'h000400, 32'h0, 50, k, sh, sa, aa);
    total++; if (a_p1_q !== 32'hCAFE_F00D) begin bad++; $display("FAIL ref_pre_q got=%h exp=cafef00d", a_p1_q); end
    m_lat = 15; m_rdata = 32'hFFFF_0000;
    run_access(1, 1, 24'h00AAAA, 32'h1234_5678, 60, k, sh, sa, aa);
    total++; if (k !== 17) begin bad++; $display("FAIL ref_latency got=%0d exp=17", k); end
    total++; if (sh !== 16) begin bad++; $display("FAIL ref_start_held got=%0d exp=16", sh); end
    total++; if (aa !== 1'b0) begin bad++; $display("FAIL ref_ack_width got=2cycles exp=1cycle"); end
    total++; if (a_p1_q !== 32'hCAFE_F00D) begin bad++; $display("FAIL ref_wr_q got=%h exp=cafef00d", a_p1_q); end
    total++; if ({a_mem_we, a_mem_addr, a_mem_d} !== {1'b1, 24'h00AAAA, 32'h1234_5678}) begin bad++; $display("FAIL ref_fields got=%b/%h/%h exp=1/00aaaa/12345678", a_mem_we, a_mem_addr, a_mem_d); end
  endtask

  task automatic test_stale_ready();
    int k, sh; bit sa, aa;
    m_stale = 1; m_lat = 9; m_rdata = 32'h1111_1111;
    run_access(0, 0, 24'h000010, 32'h0, 50, k, sh, sa, aa);
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL stale_setup got=%0b exp=1", a_ready); end
    m_rdata = 32'h2222_2222;
    run_access(0, 0, 24'h000011, 32'h0, 50, k, sh, sa, aa);
    total++; if (k !== 11) begin bad++; $display("FAIL stale_latency got=%0d exp=11", k); end
    total++; if (a_p0_q !== 32'h2222_2222) begin bad++; $display("FAIL stale_q got=%h exp=22222222", a_p0_q); end
    m_stale = 0;
  endtask

  task automatic test_watchdog();
    int k, sh; bit sa, aa;
    m_never = 1;
    run_access(0, 0, 24'h000777, 32'h0, 1100, k, sh, sa, aa);
    total++; if (k !== 1024) begin bad++; $display("FAIL wd_latency got=%0d exp=1024", k); end
    total++; if (sh !== 1023) begin bad++; $display("FAIL wd_start_len got=%0d exp=1023", sh); end
    total++; if (a_timeout_err !== 1'b1) begin bad++; $display("FAIL wd_err got=%0b exp=1", a_timeout_err); end
    total++; if (a_p0_q !== 32'h2222_2222) begin bad++; $display("FAIL wd_q got=%h exp=22222222", a_p0_q); end
    total++; if (aa !== 1'b0) begin bad++; $display("FAIL wd_ack_width got=2cycles exp=1cycle"); end
    m_never = 0; m_lat = 9; m_rdata = 32'h3333_3333;
    run_access(0, 0, 24'h000778, 32'h0, 50, k, sh, sa, aa);
    total++; if ({a_timeout_err, a_p0_q} !== {1'b1, 32'h3333_3333}) begin bad++; $display("FAIL wd_sticky got=%b/%h exp=1/33333333", a_timeout_err, a_p0_q); end
  endtask

  task automatic test_reset_mid_access();
    bit seen = 0;
    bit fin = 0;
    int n = 0;
    m_lat = 9; m_rdata = 32'h4444_4444;
    p1_we = 0; p1_addr = 24'h00F00F; p1_d = 0; p1_req = 1;
    repeat (5) @(negedge clk);
    total++; if ({a_mem_start, a_grant} !== 2'b11) begin bad++; $display("FAIL mid_issue got=%b exp=11", {a_mem_start, a_grant}); end
    reset = 1; mem_init_done = 0;
    @(negedge clk);
    total++; if ({a_mem_start, a_grant, a_p0_ack, a_p1_ack, a_timeout_err} !== 5'b0) begin bad++; $display("FAIL mid_rst_ctl got=%b exp=00000", {a_mem_start, a_grant, a_p0_ack, a_p1_ack, a_timeout_err}); end
    total++; if ({a_p0_q, a_p1_q, a_mem_addr, a_mem_d, a_mem_we} !== '0) begin bad++; $display("FAIL mid_rst_data got=%h/%h/%h/%h exp=0", a_p0_q, a_p1_q, a_mem_addr, a_mem_d); end
    reset = 0;
    repeat (10) begin @(negedge clk); if (a_mem_start !== 1'b0 || a_p1_ack !== 1'b0) seen = 1; end
    total++; if (seen) begin bad++; $display("FAIL mid_wait_init got=activity exp=none"); end
    mem_init_done = 1;
    while (!fin) begin
      @(negedge clk); n++;
      if (a_p1_ack === 1'b1) fin = 1;
      else if (n > 50) begin fin = 1; total++; bad++; $display("FAIL mid_ack got=none exp=ack"); end
    end
    p1_req = 0;
    @(negedge clk);
    total++; if (a_p1_q !== 32'h4444_4444) begin bad++; $display("FAIL mid_q got=%h exp=44444444", a_p1_q); end
  endtask

  initial begin
    test_reset();
    test_init_gating();
    test_single_read();
    test_contention();
    test_refresh();
    test_stale_ready();
    test_watchdog();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
